// File: rtl/proc_ctrl_pkg.sv
// Shared opcode, ALU phase and state definitions for the main control
// unit; ALUControl decodes the same phase codes.
package proc_ctrl_pkg;

  localparam int OPC_W = 6;

  typedef logic [OPC_W-1:0] opc_t;

  localparam opc_t OP_LW   = 6'b000000;
  localparam opc_t OP_SW   = 6'b000011;
  localparam opc_t OP_MOV  = 6'b000101;
  localparam opc_t OP_ADD  = 6'b000110;
  localparam opc_t OP_SUB  = 6'b000111;
  localparam opc_t OP_MUL  = 6'b001000;
  localparam opc_t OP_DIV  = 6'b001001;
  localparam opc_t OP_AND  = 6'b001010;
  localparam opc_t OP_OR   = 6'b001011;
  localparam opc_t OP_SHL  = 6'b001100;
  localparam opc_t OP_SHR  = 6'b001101;
  localparam opc_t OP_CMP  = 6'b001110;
  localparam opc_t OP_NOT  = 6'b001111;
  localparam opc_t OP_JR   = 6'b010000;
  localparam opc_t OP_JPC  = 6'b010001;
  localparam opc_t OP_BRFL = 6'b010010;
  localparam opc_t OP_CALL = 6'b010011;
  localparam opc_t OP_RET  = 6'b010100;
  localparam opc_t OP_NOP  = 6'b010101;

  // Memory ops take extra phase codes; all others reuse the opcode.
  localparam opc_t ALU_LW_1 = 6'd0;
  localparam opc_t ALU_LW_2 = 6'd1;
  localparam opc_t ALU_LW_3 = 6'd2;
  localparam opc_t ALU_SW_1 = 6'd3;
  localparam opc_t ALU_SW_2 = 6'd4;
  localparam opc_t ALU_MOV  = 6'd5;
  localparam opc_t ALU_ADD  = 6'd6;
  localparam opc_t ALU_SUB  = 6'd7;
  localparam opc_t ALU_MUL  = 6'd8;
  localparam opc_t ALU_DIV  = 6'd9;
  localparam opc_t ALU_AND  = 6'd10;
  localparam opc_t ALU_OR   = 6'd11;
  localparam opc_t ALU_SHL  = 6'd12;
  localparam opc_t ALU_SHR  = 6'd13;
  localparam opc_t ALU_CMP  = 6'd14;
  localparam opc_t ALU_NOT  = 6'd15;
  localparam opc_t ALU_JR   = 6'd16;
  localparam opc_t ALU_JPC  = 6'd17;
  localparam opc_t ALU_BRFL = 6'd18;
  localparam opc_t ALU_CALL = 6'd19;
  localparam opc_t ALU_RET  = 6'd20;
  localparam opc_t ALU_NOP  = 6'd21;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_ALU = 2'd1;
  localparam logic [1:0] PC_SRC_MEM = 2'd2;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_ALU = 2'd1;
  localparam logic [1:0] ADDR_SP  = 2'd2;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT_ALU,
    S_MEM_RD,
    S_WB,
    S_MEM_WR
  } state_t;

  typedef struct packed {
    opc_t       alu_op;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] addr_src;
    logic       reg_write;
    logic       wb_src;
    logic       flag_write;
    logic       sp_push;
    logic       sp_pop;
    logic       illegal;
    logic       fault;
    logic       retired;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c            = '0;
    c.alu_op     = ALU_NOP;
    c.pc_src     = PC_SRC_INC;
    c.addr_src   = ADDR_PC;
    c.wb_src     = WB_ALU;
    return c;
  endfunction

  function automatic logic is_legal(opc_t op);
    logic r;
    case (op)
      OP_LW, OP_SW, OP_MOV, OP_ADD, OP_SUB,
      OP_MUL, OP_DIV, OP_AND, OP_OR, OP_SHL,
      OP_SHR, OP_CMP, OP_NOT, OP_JR, OP_JPC,
      OP_BRFL, OP_CALL, OP_RET, OP_NOP:
        r = 1'b1;
      default:
        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_arith(opc_t op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHL, OP_SHR, OP_NOT, OP_MOV:
        r = 1'b1;
      default:
        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_branch(opc_t op);
    return (op == OP_JR) || (op == OP_JPC) ||
           (op == OP_BRFL);
  endfunction

  function automatic logic is_muldiv(opc_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic opc_t phase1(opc_t op);
    opc_t r;
    case (op)
      OP_LW:   r = ALU_LW_1;
      OP_SW:   r = ALU_SW_1;
      default: r = op;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/proc_control_fsm.sv
// Multi-cycle main control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory handshake and bounded MUL/DIV wait.
module proc_control_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int MULDIV_TIMEOUT = 32,
  parameter int OP_W           = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] instr_op,
  input  logic            cond_true,
  input  logic            mem_ready,
  input  logic            alu_done,
  output logic [OP_W-1:0] alu_op,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      mem_addr_src,
  output logic            reg_write,
  output logic            wb_src,
  output logic            flag_write,
  output logic            sp_push,
  output logic            sp_pop,
  output logic            illegal_op,
  output logic            exec_fault,
  output logic            instr_retired
);

  localparam int CW = $clog2(MULDIV_TIMEOUT);

  state_t          r_state;
  state_t          w_next;
  logic [OP_W-1:0] r_op;
  logic [CW-1:0]   r_cnt;
  logic            w_to;
  ctrl_t           w_c;

  assign w_to = (r_cnt == CW'(MULDIV_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_op <= instr_op;
      if (r_state == S_WAIT_ALU &&
          w_next == S_WAIT_ALU)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    w_next = r_state;
    w_c    = ctrl_idle();
    unique case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end

      S_FETCH: begin
        w_c.mem_read = 1'b1;
        w_c.addr_src = ADDR_PC;
        if (mem_ready) begin
          w_c.ir_write = 1'b1;
          w_c.pc_write = 1'b1;
          w_c.pc_src   = PC_SRC_INC;
          w_next       = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_legal(instr_op)) begin
          w_next = S_EXEC;
        end else begin
          w_c.illegal = 1'b1;
          w_c.retired = 1'b1;
          w_next      = S_FETCH;
        end
      end

      S_EXEC: begin
        w_c.alu_op = phase1(r_op);
        unique case (1'b1)
          is_arith(r_op): begin
            w_c.reg_write  = 1'b1;
            w_c.wb_src     = WB_ALU;
            w_c.flag_write = (r_op != OP_MOV);
            w_c.retired    = 1'b1;
            w_next         = S_FETCH;
          end
          (r_op == OP_CMP): begin
            w_c.flag_write = 1'b1;
            w_c.retired    = 1'b1;
            w_next         = S_FETCH;
          end
          is_branch(r_op): begin
            if (r_op == OP_JR || cond_true) begin
              w_c.pc_write = 1'b1;
              w_c.pc_src   = PC_SRC_ALU;
            end
            w_c.retired = 1'b1;
            w_next      = S_FETCH;
          end
          is_muldiv(r_op): begin
            w_next = S_WAIT_ALU;
          end
          (r_op == OP_LW || r_op == OP_RET): begin
            w_next = S_MEM_RD;
          end
          (r_op == OP_SW): begin
            w_next = S_MEM_WR;
          end
          (r_op == OP_CALL): begin
            w_c.sp_push = 1'b1;
            w_next      = S_MEM_WR;
          end
          default: begin
            w_c.retired = 1'b1;
            w_next      = S_FETCH;
          end
        endcase
      end

      S_WAIT_ALU: begin
        w_c.alu_op = r_op;
        // Completion wins over timeout in the same cycle.
        if (alu_done) begin
          w_c.reg_write  = 1'b1;
          w_c.flag_write = 1'b1;
          w_c.retired    = 1'b1;
          w_next         = S_FETCH;
        end else if (w_to) begin
          w_c.fault = 1'b1;
          w_next    = S_FETCH;
        end
      end

      S_MEM_RD: begin
        w_c.mem_read = 1'b1;
        if (r_op == OP_RET) begin
          w_c.alu_op   = ALU_NOP;
          w_c.addr_src = ADDR_SP;
          if (mem_ready) begin
            w_c.pc_write = 1'b1;
            w_c.pc_src   = PC_SRC_MEM;
            w_c.sp_pop   = 1'b1;
            w_c.retired  = 1'b1;
            w_next       = S_FETCH;
          end
        end else begin
          w_c.alu_op   = ALU_LW_2;
          w_c.addr_src = ADDR_ALU;
          if (mem_ready)
            w_next = S_WB;
        end
      end

      S_WB: begin
        w_c.alu_op    = ALU_LW_3;
        w_c.reg_write = 1'b1;
        w_c.wb_src    = WB_MEM;
        w_c.retired   = 1'b1;
        w_next        = S_FETCH;
      end

      S_MEM_WR: begin
        w_c.mem_write = 1'b1;
        if (r_op == OP_CALL) begin
          w_c.alu_op   = ALU_NOP;
          w_c.addr_src = ADDR_SP;
          if (mem_ready) begin
            w_c.pc_write = 1'b1;
            w_c.pc_src   = PC_SRC_ALU;
            w_c.retired  = 1'b1;
            w_next       = S_FETCH;
          end
        end else begin
          w_c.alu_op   = ALU_SW_2;
          w_c.addr_src = ADDR_ALU;
          if (mem_ready) begin
            w_c.retired = 1'b1;
            w_next      = S_FETCH;
          end
        end
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign alu_op        = w_c.alu_op;
  assign ir_write      = w_c.ir_write;
  assign pc_write      = w_c.pc_write;
  assign pc_src        = w_c.pc_src;
  assign mem_read      = w_c.mem_read;
  assign mem_write     = w_c.mem_write;
  assign mem_addr_src  = w_c.addr_src;
  assign reg_write     = w_c.reg_write;
  assign wb_src        = w_c.wb_src;
  assign flag_write    = w_c.flag_write;
  assign sp_push       = w_c.sp_push;
  assign sp_pop        = w_c.sp_pop;
  assign illegal_op    = w_c.illegal;
  assign exec_fault    = w_c.fault;
  assign instr_retired = w_c.retired;

  a_rw_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(mem_read && mem_write));

  a_fault_quiet: assert property (
    @(posedge clk) disable iff (!rst_n)
    exec_fault |-> !(reg_write || instr_retired));

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench for proc_control_fsm: per-cycle expected strobe
// vectors queued by the stimulus, checked by an independent monitor.
module tb_proc_control_fsm;

  typedef logic [21:0] vec_t;

  localparam logic [5:0] C_LW   = 6'b000000;
  localparam logic [5:0] C_SW   = 6'b000011;
  localparam logic [5:0] C_MOV  = 6'b000101;
  localparam logic [5:0] C_ADD  = 6'b000110;
  localparam logic [5:0] C_MUL  = 6'b001000;
  localparam logic [5:0] C_DIV  = 6'b001001;
  localparam logic [5:0] C_CMP  = 6'b001110;
  localparam logic [5:0] C_JR   = 6'b010000;
  localparam logic [5:0] C_JPC  = 6'b010001;
  localparam logic [5:0] C_CALL = 6'b010011;
  localparam logic [5:0] C_RET  = 6'b010100;
  localparam logic [5:0] C_NOP  = 6'b010101;

  localparam logic [15:0] IR   = 16'h8000;
  localparam logic [15:0] PCW  = 16'h4000;
  localparam logic [15:0] PCSM = 16'h2000;
  localparam logic [15:0] PCSA = 16'h1000;
  localparam logic [15:0] MR   = 16'h0800;
  localparam logic [15:0] MW   = 16'h0400;
  localparam logic [15:0] ASSP = 16'h0200;
  localparam logic [15:0] ASA  = 16'h0100;
  localparam logic [15:0] RW   = 16'h0080;
  localparam logic [15:0] WBM  = 16'h0040;
  localparam logic [15:0] FW   = 16'h0020;
  localparam logic [15:0] PUSH = 16'h0010;
  localparam logic [15:0] POP  = 16'h0008;
  localparam logic [15:0] ILL  = 16'h0004;
  localparam logic [15:0] FLT  = 16'h0002;
  localparam logic [15:0] RET  = 16'h0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] instr_op = C_NOP;
  logic       cond_true = 1'b0;
  logic       mem_ready = 1'b0;
  logic       alu_done = 1'b0;
  logic [5:0] alu_op;
  logic       ir_write, pc_write;
  logic [1:0] pc_src, mem_addr_src;
  logic       mem_read, mem_write;
  logic       reg_write, wb_src, flag_write;
  logic       sp_push, sp_pop;
  logic       illegal_op, exec_fault, instr_retired;

  vec_t       q_exp[$];
  string      q_nm[$];
  int         n_run = 0;
  int         n_fail = 0;
  logic [5:0] op = C_NOP;
  vec_t       act;

  always #5 clk = ~clk;

  proc_control_fsm #(
    .MULDIV_TIMEOUT(8),
    .OP_W(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_op(instr_op),
    .cond_true(cond_true),
    .mem_ready(mem_ready),
    .alu_done(alu_done),
    .alu_op(alu_op),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr_src(mem_addr_src),
    .reg_write(reg_write),
    .wb_src(wb_src),
    .flag_write(flag_write),
    .sp_push(sp_push),
    .sp_pop(sp_pop),
    .illegal_op(illegal_op),
    .exec_fault(exec_fault),
    .instr_retired(instr_retired)
  );

  assign act = {alu_op, ir_write, pc_write, pc_src,
                mem_read, mem_write, mem_addr_src,
                reg_write, wb_src, flag_write, sp_push,
                sp_pop, illegal_op, exec_fault,
                instr_retired};

  function automatic vec_t mk(logic [5:0] a,
                              logic [15:0] s);
    return {a, s};
  endfunction

  task automatic cyc(string nm, vec_t e, bit rdy = 1,
                     bit cnd = 0, bit dn = 0, bit rs = 1);
    @(posedge clk);
    #1;
    rst_n     = rs;
    mem_ready = rdy;
    cond_true = cnd;
    alu_done  = dn;
    instr_op  = op;
    q_exp.push_back(e);
    q_nm.push_back(nm);
  endtask

  task automatic fd(string nm);
    cyc({nm, "_f"}, mk(C_NOP, MR | IR | PCW));
    cyc({nm, "_d"}, mk(C_NOP, 16'h0));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        vec_t  e;
        string n;
        e = q_exp.pop_front();
        n = q_nm.pop_front();
        n_run++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got alu=%b ctl=%b want alu=%b ctl=%b",
                   n, act[21:16], act[15:0], e[21:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    cyc("rst", mk(C_NOP, 16'h0), 1, 0, 0, 0);
    cyc("rst_idle", mk(C_NOP, 16'h0));

    op = C_ADD;
    fd("add");
    cyc("add_x", mk(C_ADD, RW | FW | RET));

    op = C_LW;
    fd("lw");
    cyc("lw_x", mk(6'd0, 16'h0));
    for (int i = 0; i < 3; i++)
      cyc("lw_hold", mk(6'd1, MR | ASA), 0);
    cyc("lw_rd", mk(6'd1, MR | ASA), 1);
    cyc("lw_wb", mk(6'd2, RW | WBM | RET));

    op = C_MUL;
    fd("mul");
    cyc("mul_x", mk(C_MUL, 16'h0));
    for (int i = 0; i < 4; i++)
      cyc("mul_w", mk(C_MUL, 16'h0));
    cyc("mul_done", mk(C_MUL, RW | FW | RET), 1, 0, 1);

    fd("mto");
    cyc("mto_x", mk(C_MUL, 16'h0));
    for (int i = 0; i < 7; i++)
      cyc("mto_w", mk(C_MUL, 16'h0));
    cyc("mto_flt", mk(C_MUL, FLT));

    op = C_DIV;
    fd("div");
    cyc("div_x", mk(C_DIV, 16'h0));
    for (int i = 0; i < 7; i++)
      cyc("div_w", mk(C_DIV, 16'h0));
    cyc("div_edge", mk(C_DIV, RW | FW | RET), 1, 0, 1);

    op = C_JPC;
    cyc("jpc0_fw", mk(C_NOP, MR), 0);
    fd("jpc0");
    cyc("jpc0_x", mk(C_JPC, RET), 1, 0);
    fd("jpc1");
    cyc("jpc1_x", mk(C_JPC, PCW | PCSA | RET), 1, 1);

    op = C_JR;
    fd("jr");
    cyc("jr_x", mk(C_JR, PCW | PCSA | RET), 1, 0);

    op = C_MOV;
    fd("mov");
    cyc("mov_x", mk(C_MOV, RW | RET));
    op = C_CMP;
    fd("cmp");
    cyc("cmp_x", mk(C_CMP, FW | RET));
    op = C_NOP;
    fd("nop");
    cyc("nop_x", mk(C_NOP, RET));

    op = C_CALL;
    fd("call");
    cyc("call_x", mk(C_CALL, PUSH));
    cyc("call_hold", mk(C_NOP, MW | ASSP), 0);
    cyc("call_wr", mk(C_NOP, MW | ASSP | PCW | PCSA | RET));

    op = C_RET;
    fd("ret");
    cyc("ret_x", mk(C_RET, 16'h0));
    cyc("ret_hold", mk(C_NOP, MR | ASSP), 0);
    cyc("ret_rd",
        mk(C_NOP, MR | ASSP | PCW | PCSM | POP | RET));

    op = C_SW;
    fd("sw");
    cyc("sw_x", mk(6'd3, 16'h0));
    cyc("sw_wr", mk(6'd4, MW | ASA | RET));

    op = 6'b111111;
    cyc("ill_f", mk(C_NOP, MR | IR | PCW));
    cyc("ill_d", mk(C_NOP, ILL | RET));
    op = 6'b000001;
    cyc("ill2_f", mk(C_NOP, MR | IR | PCW));
    cyc("ill2_d", mk(C_NOP, ILL | RET));

    op = C_SW;
    fd("swr");
    cyc("swr_x", mk(6'd3, 16'h0));
    cyc("swr_hold", mk(6'd4, MW | ASA), 0);
    cyc("rst_mid", mk(C_NOP, 16'h0), 0, 0, 0, 0);
    cyc("rst_idle2", mk(C_NOP, 16'h0), 1, 0, 0, 1);
    cyc("rst_fetch", mk(C_NOP, MR | IR | PCW));

    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0",
               q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
Multi-cycle main control unit for the processor core. Sequences fetch/decode/execute/memory/writeback for every instruction opcode. Drives the 6-bit per-phase ALUOp code consumed by ALUControl, plus all PC/IR/memory/register-file/stack strobes. Handles memory ready handshakes and the variable-latency MUL/DIV wait.

Parameters:
MULDIV_TIMEOUT, 32, max cycles in S_WAIT_ALU without alu_done before abort (legal range ≥2)
OP_W, 6, width of opcode and ALUOp codes

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_op  in  6  opcode field of instruction register; valid from S_DECODE on
cond_true  in  1  flag condition evaluated for JPC/BRFL
mem_ready  in  1  memory access complete this cycle
alu_done  in  1  MUL/DIV result valid this cycle
alu_op  out  6  phase code to ALUControl (LW_1..NOP encoding)
ir_write  out  1  load instruction register
pc_write  out  1  load PC
pc_src  out  2  0=PC+1, 1=ALU result, 2=memory data
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_addr_src  out  2  0=PC, 1=ALU result, 2=SP
reg_write  out  1  register-file write enable
wb_src  out  1  0=ALU result, 1=memory data
flag_write  out  1  update flags register
sp_push  out  1  decrement SP (one-cycle pulse)
sp_pop  out  1  increment SP (one-cycle pulse)
illegal_op  out  1  one-cycle pulse, undefined opcode decoded
exec_fault  out  1  one-cycle pulse, MUL/DIV timeout
instr_retired  out  1  one-cycle pulse on last cycle of each instruction

Behaviour:
- Opcodes: LW=000000, SW=000011, MOV=000101, ADD=000110, SUB=000111, MUL=001000, DIV=001001, AND=001010, OR=001011, SHL=001100, SHR=001101, CMP=001110, NOT=001111, JR=010000, JPC=010001, BRFL=010010, CALL=010011, RET=010100, NOP=010101. Any other value is illegal.
- Reset: state=S_IDLE, op_q=NOP, timeout counter=0. All strobes 0, pc_src/mem_addr_src/wb_src=0, alu_op=NOP.
- Outputs are combinational decode of (state, op_q, inputs); op_q is latched in S_DECODE.
- S_IDLE: outputs idle; next state S_FETCH unconditionally.
- S_FETCH: mem_read=1, addr_src=PC, alu_op=NOP. Hold until mem_ready. In the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0. Next state S_DECODE.
- S_DECODE: alu_op=NOP; latch op_q<=instr_op. Illegal opcode: illegal_op=1, instr_retired=1, next S_FETCH. Otherwise next S_EXEC.
- S_EXEC, alu_op = op_q's phase-1 code:
  - ADD/SUB/AND/OR/SHL/SHR/NOT/MOV: reg_write=1, wb_src=0, flag_write=1 (MOV: flag_write=0); retire; next S_FETCH.
  - CMP: flag_write only; retire.
  - NOP/BRFL with cond_true=0, JPC with cond_true=0: retire.
  - JR, or JPC/BRFL with cond_true=1: pc_write=1, pc_src=1; retire.
  - MUL/DIV: next S_WAIT_ALU.
  - LW (LW_1): next S_MEM_RD.
  - SW (SW_1): next S_MEM_WR.
  - CALL: sp_push=1; next S_MEM_WR.
  - RET: next S_MEM_RD.
- S_WAIT_ALU: alu_op held at MUL/DIV; counter increments each cycle.
  - alu_done: reg_write=1, flag_write=1; retire; next S_FETCH. alu_done has priority over timeout in the same cycle.
  - Counter reaches MULDIV_TIMEOUT-1 without alu_done: exec_fault=1, no writes, no retire; next S_FETCH.
  - Counter clears on state exit.
- S_MEM_RD: mem_read=1.
  - LW: alu_op=LW_2, addr_src=1; on mem_ready next S_WB.
  - RET: alu_op=NOP, addr_src=2; on mem_ready: pc_write=1, pc_src=2, sp_pop=1; retire; next S_FETCH.
- S_WB (LW only): alu_op=LW_3, reg_write=1, wb_src=1; retire; next S_FETCH.
- S_MEM_WR: mem_write=1.
  - SW: alu_op=SW_2, addr_src=1; on mem_ready retire, next S_FETCH.
  - CALL: addr_src=2, alu_op=NOP; on mem_ready: pc_write=1, pc_src=1; retire.
- While waiting for mem_ready, request/address outputs are held stable and no other strobe fires.
- Minimum latency with mem_ready tied high: ALU op 3 cycles, LW 5 cycles, SW/CALL/RET 4 cycles.
- rst_n low at any point: immediate return to reset values; in-flight access is abandoned.

Decomposition:
- Package proc_ctrl_pkg holds: opcode/phase localparams, the ALU_* Operation codes, the state enum, and the pc_src/addr_src/wb_src encodings. The same package is shared with ALUControl and its bench.
- Single module, no sub-module.

Test Plan:
- Reset released, mem_ready=1, instr_op=ADD -> IDLE, FETCH, DECODE, EXEC; reg_write and flag_write high in cycle 4 with alu_op=000110; instr_retired pulses once.
- LW with mem_ready delayed 3 cycles in S_MEM_RD -> alu_op sequence 000000, 000001 (held 4 cycles, mem_read=1, addr_src=1), then 000010 with reg_write=1, wb_src=1.
- MUL with alu_done after 5 cycles -> single reg_write pulse. MUL with alu_done never high, MULDIV_TIMEOUT=8 -> exec_fault pulse after 8 wait cycles, no reg_write, back to FETCH.
- JPC with cond_true=0 -> no pc_write in EXEC. JPC with cond_true=1 -> pc_write=1, pc_src=1.
- CALL then RET -> CALL: sp_push in EXEC, mem_write with addr_src=2, pc_src=1. RET: mem_read addr_src=2, sp_pop with pc_write and pc_src=2.
- instr_op=111111 -> illegal_op pulse in DECODE, no write strobes, next FETCH. rst_n pulled low mid-S_MEM_WR -> mem_write drops asynchronously, state S_IDLE.
